ct_mem_arb: RTL and testbench
=============================

# ct_mem_arb

Round-robin arbiter that shares the single read port of the ciphertext memory (`ct_mem`) between NREQ crack engines. It sits between the engines' `ct_addr`/`ct_rddata` ports and the synchronous one-cycle-latency `ct_mem` instance. Each read is sequenced by an FSM, and the result is returned with a per-requester valid pulse. A lock input lets an engine run a burst of back-to-back reads (length byte, then message bytes). The burst is capped so that other engines are never starved indefinitely.

## Interface

Parameters:
- NREQ, 2, number of requesting crack engines (2..8)
- AW, 8, ct_mem address width
- DW, 8, ct_mem data width
- MAX_BURST, 16, maximum consecutive locked grants to one owner before lock is ignored once; 0 = unlimited

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-engine read request, level
- lock  in  NREQ  per-engine burst hold, meaningful only for current owner
- addr  in  NREQ*AW  flattened request addresses; engine i at [i*AW +: AW]
- rd_valid  out  NREQ  one-cycle pulse to the owner when rd_data is valid
- rd_data  out  DW  registered read data, shared by all engines
- owner  out  $clog2(NREQ)  index of the engine granted the current/last transaction
- busy  out  1  high when FSM is not IDLE
- ct_addr  out  AW  registered address to ct_mem
- ct_rddata  in  DW  ct_mem q output, valid one cycle after ct_addr is sampled

## Operation

- FSM states and transitions:
  - IDLE: arbitrate when any req is high; latch the winner's addr into ct_addr; set owner; go to ADDR. With no req, stay in IDLE.
  - ADDR: ct_mem samples ct_addr at the end of this cycle; go to WAIT.
  - WAIT: capture ct_rddata into rd_data; set rd_valid[owner]; go to DONE.
  - DONE: rd_valid[owner] is high, all other rd_valid bits are low. Re-arbitrate in this cycle exactly as in IDLE. Go to ADDR if a winner exists, otherwise go to IDLE.
- Arbitration, evaluated in IDLE and DONE:
  - In DONE, if req[owner] and lock[owner] are both high and the burst count is below MAX_BURST, the owner is kept. Its new addr is latched and the burst count is incremented.
  - Otherwise, round-robin applies: search begins at the rr pointer, and the first asserted req wins.
  - On every non-locked grant, rr is set to winner+1 mod NREQ and the burst count is set to 1.
  - After a cap-forced release, the old owner has lowest priority.
- Request rule: req high in DONE is a new request. An engine with no further reads must drop req combinationally on rd_valid.
- req or addr changing during ADDR or WAIT has no effect. The transaction completes and rd_valid still pulses.
- lock without req, or lock on a non-owner, is ignored.
- With MAX_BURST nonzero, every pending requester is granted within NREQ·MAX_BURST transactions.

## Timing

- Reset (async, immediate) values:
  - state IDLE, rr 0 (engine 0 has first priority), burst count 0
  - ct_addr 0, rd_data 0, rd_valid 0, owner 0, busy 0
- Reset asserted mid-transaction: no rd_valid pulse is issued, and the read is dropped.
- Latency: req first high in IDLE at cycle N gives ct_addr valid at N+1, ct_rddata valid at N+2, and rd_valid/rd_data at N+3.
- Locked burst: one read every 3 cycles (DONE→ADDR→WAIT→DONE). Unlocked switch to another pending engine has the same 3-cycle cadence.
- rd_data holds its value until the next WAIT capture.
- busy is high from the cycle after the IDLE grant through DONE. It falls in the cycle after DONE only if no request is pending.
- Simultaneous requests from all engines after reset: engine 0 wins, then 1, and so on in index order.

## Test plan

- Single read: preload ct_mem[0]=0x49; assert req[0], addr0=0x00 at cycle N → ct_addr=0x00 at N+1, rd_valid=2'b01 with rd_data=0x49 at N+3, busy=0 at N+4.
- Round-robin: req=2'b11 held, addr0=0x01, addr1=0x02, mem[1]=0xA5, mem[2]=0x3C → grants alternate 0,1,0,1, returning 0xA5/0x3C; owner toggles every 3 cycles.
- Locked burst with cap: MAX_BURST=4, engine 0 lock=1 reading addr 1..6, engine 1 req held → engine 0 gets 4 reads, engine 1 gets 1, then engine 0 resumes.
- Request drop mid-transaction: req[1] dropped in ADDR → rd_valid[1] still pulses at N+3 with correct data; FSM returns to IDLE.
- Reset mid-op: assert rst during WAIT → rd_valid stays 0, all outputs are at reset values immediately, and the next req[0] is served with normal N+3 latency.
- Idle stability: no req for 20 cycles → busy=0, ct_addr unchanged, rd_valid=0 throughout.

Source files
------------

// File: rtl/ct_mem_arb.sv
// ct_mem_arb: round-robin arbiter that shares the single read port of the
// ciphertext memory between NREQ crack engines. Each read is sequenced as
// IDLE/DONE (grant) -> ADDR (memory samples ct_addr) -> WAIT (capture data)
// -> DONE (rd_valid pulse to the owner). An owner holding lock keeps the
// port for up to MAX_BURST consecutive reads (0 = unlimited).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req        per-engine read request (level)
//   lock       per-engine burst hold, honoured only for the current owner
//   addr       flattened request addresses, engine i at [i*AW +: AW]
//   rd_valid   one-cycle pulse to the owner when rd_data is valid
//   rd_data    registered read data, shared by all engines
//   owner      index of the engine granted the current/last transaction
//   busy       high whenever the FSM is not idle
//   ct_addr    registered address to ct_mem
//   ct_rddata  ct_mem read data, valid one cycle after ct_addr is sampled
module ct_mem_arb #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*AW-1:0]       addr,
    output logic [NREQ-1:0]          rd_valid,
    output logic [DW-1:0]            rd_data,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic [AW-1:0]            ct_addr,
    input  logic [DW-1:0]            ct_rddata
);

    localparam int unsigned OW  = $clog2(NREQ);
    // Wide enough to hold MAX_BURST; at least one bit when MAX_BURST is 0.
    localparam int unsigned BCW = $clog2(MAX_BURST + 2);

    typedef enum logic [1:0] {StIdle, StAddr, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   rr_q, rr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [BCW-1:0]  burst_q, burst_d;
    logic [AW-1:0]   ct_addr_q, ct_addr_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic [NREQ-1:0] rd_valid_q, rd_valid_d;

    logic            rr_found;
    logic [OW-1:0]   rr_idx;
    logic [OW-1:0]   cand;
    logic            burst_ok;
    logic            keep;
    logic            grant_any;
    logic [OW-1:0]   grant_idx;
    logic [AW-1:0]   grant_addr;

    // Round-robin search starting at rr_q; first asserted request wins.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = OW'((32'(rr_q) + 32'(i)) % NREQ);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // The owner keeps the port only from DONE, only with req and lock both
    // high, and only while under the burst cap. rr_q already points past the
    // owner, so a cap-forced release leaves the old owner with lowest priority.
    always_comb begin
        burst_ok  = (MAX_BURST == 0) || (burst_q < BCW'(MAX_BURST));
        keep      = (state_q == StDone) && req[owner_q] && lock[owner_q] && burst_ok;
        grant_any = keep || rr_found;
        grant_idx = keep ? owner_q : rr_idx;
        grant_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (OW'(i) == grant_idx) begin
                grant_addr = addr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        burst_d    = burst_q;
        ct_addr_d  = ct_addr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        case (state_q)
            StIdle, StDone: begin
                if (grant_any) begin
                    state_d   = StAddr;
                    owner_d   = grant_idx;
                    ct_addr_d = grant_addr;
                    if (keep) begin
                        burst_d = burst_q + 1'b1;
                    end else begin
                        rr_d    = OW'((32'(rr_idx) + 32'd1) % NREQ);
                        burst_d = BCW'(1);
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StAddr: state_d = StWait;
            StWait: begin
                state_d   = StDone;
                rd_data_d = ct_rddata;
                for (int i = 0; i < NREQ; i++) begin
                    rd_valid_d[i] = (OW'(i) == owner_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_q       <= '0;
            owner_q    <= '0;
            burst_q    <= '0;
            ct_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            burst_q    <= burst_d;
            ct_addr_q  <= ct_addr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign owner    = owner_q;
    assign busy     = (state_q != StIdle);
    assign ct_addr  = ct_addr_q;

endmodule

// File: tb/tb_ct_mem_arb.sv
// Directed bench for ct_mem_arb (NREQ=2, MAX_BURST=4) with a behavioural
// one-cycle-latency ct_mem. Inputs change and outputs are sampled on the
// falling edge.
module tb_ct_mem_arb;

    localparam int unsigned NREQ      = 2;
    localparam int unsigned AW        = 8;
    localparam int unsigned DW        = 8;
    localparam int unsigned MAX_BURST = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      lock;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ-1:0]      rd_valid;
    logic [DW-1:0]        rd_data;
    logic [0:0]           owner;
    logic                 busy;
    logic [AW-1:0]        ct_addr;
    logic [DW-1:0]        ct_rddata;

    logic [DW-1:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    // Expected owner/data for the locked-burst scenario.
    int            bown [7] = '{0, 0, 0, 0, 1, 0, 0};
    logic [7:0]    bdat [7] = '{8'hA5, 8'h3C, 8'h11, 8'h22, 8'h77, 8'h33, 8'h44};

    ct_mem_arb #(
        .NREQ      (NREQ),
        .AW        (AW),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .addr      (addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .owner     (owner),
        .busy      (busy),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ct_rddata <= mem[ct_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]     = 8'h49;
        mem[1]     = 8'hA5;
        mem[2]     = 8'h3C;
        mem[3]     = 8'h11;
        mem[4]     = 8'h22;
        mem[5]     = 8'h33;
        mem[6]     = 8'h44;
        mem[8'h10] = 8'h77;

        rst  = 1'b1;
        req  = '0;
        lock = '0;
        addr = '0;
        cyc(2);
        check_eq("rst_busy",     32'(busy),     32'h0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'h0);
        check_eq("rst_owner",    32'(owner),    32'h0);
        check_eq("rst_ct_addr",  32'(ct_addr),  32'h0);
        check_eq("rst_rd_data",  32'(rd_data),  32'h0);
        rst = 1'b0;

        // Single read from engine 0.
        cyc(1);
        req        = 2'b01;
        addr[7:0]  = 8'h00;
        cyc(1);
        check_eq("single_ct_addr", 32'(ct_addr),  32'h00);
        check_eq("single_busy",    32'(busy),     32'h1);
        check_eq("single_rv_n1",   32'(rd_valid), 32'h0);
        cyc(1);
        check_eq("single_rv_n2",   32'(rd_valid), 32'h0);
        cyc(1);
        check_eq("single_rv_n3",   32'(rd_valid), 32'h1);
        check_eq("single_data",    32'(rd_data),  32'h49);
        req = 2'b00;
        cyc(1);
        check_eq("single_busy_n4", 32'(busy),     32'h0);
        check_eq("single_rv_n4",   32'(rd_valid), 32'h0);
        check_eq("single_hold",    32'(rd_data),  32'h49);

        // Round-robin between two continuously requesting engines.
        do_reset();
        req        = 2'b11;
        addr[7:0]  = 8'h01;
        addr[15:8] = 8'h02;
        cyc(1);
        check_eq("rr_first_owner", 32'(owner), 32'h0);
        cyc(2);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) cyc(3);
            check_eq("rr_valid", 32'(rd_valid), (k % 2 == 1) ? 32'h2 : 32'h1);
            check_eq("rr_data",  32'(rd_data),  (k % 2 == 1) ? 32'h3C : 32'hA5);
            check_eq("rr_owner", 32'(owner),    32'(k % 2));
        end
        req = 2'b00;
        cyc(1);
        check_eq("rr_idle", 32'(busy), 32'h0);

        // Locked burst from engine 0, capped at MAX_BURST, engine 1 pending.
        do_reset();
        req        = 2'b11;
        lock       = 2'b01;
        addr[7:0]  = 8'h01;
        addr[15:8] = 8'h10;
        for (int k = 0; k < 7; k++) begin
            cyc(3);
            check_eq("burst_valid", 32'(rd_valid), (bown[k] == 1) ? 32'h2 : 32'h1);
            check_eq("burst_data",  32'(rd_data),  32'(bdat[k]));
            if (bown[k] == 0) addr[7:0] = addr[7:0] + 8'h01;
            else              req[1]    = 1'b0;
        end
        req  = 2'b00;
        lock = 2'b00;
        cyc(1);
        check_eq("burst_idle", 32'(busy), 32'h0);

        // Request and address drop during ADDR are ignored.
        do_reset();
        req        = 2'b10;
        addr[15:8] = 8'h02;
        cyc(1);
        check_eq("drop_owner", 32'(owner), 32'h1);
        req        = 2'b00;
        addr[15:8] = 8'h10;
        cyc(2);
        check_eq("drop_valid", 32'(rd_valid), 32'h2);
        check_eq("drop_data",  32'(rd_data),  32'h3C);
        cyc(1);
        check_eq("drop_idle",  32'(busy),     32'h0);

        // Reset during WAIT drops the read.
        req       = 2'b01;
        addr[7:0] = 8'h01;
        cyc(1);
        check_eq("rstmid_ct_addr", 32'(ct_addr), 32'h01);
        req = 2'b00;
        cyc(1);
        rst = 1'b1;
        #1;
        check_eq("rstmid_valid",   32'(rd_valid), 32'h0);
        check_eq("rstmid_busy",    32'(busy),     32'h0);
        check_eq("rstmid_ct_addr", 32'(ct_addr),  32'h0);
        check_eq("rstmid_owner",   32'(owner),    32'h0);
        check_eq("rstmid_data",    32'(rd_data),  32'h0);
        cyc(1);
        check_eq("rstmid_no_pulse", 32'(rd_valid), 32'h0);
        rst       = 1'b0;
        req       = 2'b01;
        addr[7:0] = 8'h02;
        cyc(2);
        check_eq("post_rst_rv_n2", 32'(rd_valid), 32'h0);
        cyc(1);
        check_eq("post_rst_valid", 32'(rd_valid), 32'h1);
        check_eq("post_rst_data",  32'(rd_data),  32'h3C);
        req = 2'b00;

        // Idle stability.
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            check_eq("idle_busy",    32'(busy),     32'h0);
            check_eq("idle_valid",   32'(rd_valid), 32'h0);
            check_eq("idle_ct_addr", 32'(ct_addr),  32'h02);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
